dmem_resp: RTL and testbench

Data-memory responder for the single-cycle rv32i core: the target end of the core's dmem port. It decodes the byte address the core drives and serves a 2 kB word RAM, a memory-mapped UART transmitter with a small FIFO, and a free-running cycle counter. Reads are combinational so a load completes in the same cycle. Writes take effect on the clock edge.

---
 rtl/dmem_resp.sv | 223 ++++++++++++++++++++++
 tb/tb_dmem_resp.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory target for the rv32i core (512x32 RAM, UART TX with FIFO, cycle counter).
// Latency: reads are combinational (0 cycles, pre-edge state); writes land on the next rising edge.
// Backpressure: none; TXDATA pushes into a full FIFO are dropped and flagged in sticky STATUS.overflow.
//
// Ports:
//   clk, reset                   system clock, asynchronous active-high reset
//   dmem_addr_i / dmem_w_i       byte address and write strobe from the core
//   dmem_w_data_i                full-word write data
//   dmem_r_data_o                combinational read data
//   uart_tx_o                    8N1 serial output, idle high
//
// Address map (full 32-bit decode):
//   0x0000_0000-0x0000_07FF RAM, 0x1000_0000 TXDATA, 0x1000_0004 STATUS, 0x1000_0008 CYCLE.
// CLKS_PER_BIT must be >= 2; FIFO_DEPTH must be a power of 2, >= 2.
module dmem_resp #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_addr_i,
  input  logic        dmem_w_i,
  input  logic [31:0] dmem_w_data_i,
  output logic [31:0] dmem_r_data_o,
  output logic        uart_tx_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [31:0]    ADDR_TXDATA = 32'h1000_0000;
  localparam logic [31:0]    ADDR_STATUS = 32'h1000_0004;
  localparam logic [31:0]    ADDR_CYCLE  = 32'h1000_0008;
  localparam logic [BW-1:0]  BAUD_LOAD   = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  FIFO_FULL   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- decode
  logic       ram_sel;
  logic       tx_sel;
  logic       st_sel;
  logic       cyc_sel;
  logic [8:0] ram_idx;
  logic       ram_we;

  assign ram_sel = (dmem_addr_i[31:11] == 21'd0);
  assign tx_sel  = (dmem_addr_i == ADDR_TXDATA);
  assign st_sel  = (dmem_addr_i == ADDR_STATUS);
  assign cyc_sel = (dmem_addr_i == ADDR_CYCLE);
  assign ram_idx = dmem_addr_i[10:2];
  assign ram_we  = dmem_w_i && ram_sel;

  // ---------------------------------------------------------------- RAM
  // Contents are never cleared; reset only blocks writes while asserted.
  logic [31:0] mem [512];

  always_ff @(posedge clk or posedge reset) begin
    if (!reset && ram_we) begin
      mem[ram_idx] <= dmem_w_data_i;
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          push;
  logic          push_ok;
  logic          pop;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          busy;

  // Full is taken from the pre-edge count, so a simultaneous pop never
  // rescues a push into a full FIFO.
  assign full    = (count == FIFO_FULL);
  assign empty   = (count == '0);
  assign push    = dmem_w_i && tx_sel;
  assign push_ok = push && !full;
  // The UART takes a byte either from IDLE or on the final STOP cycle,
  // the latter giving back-to-back frames.
  assign pop     = !empty && ((state == S_IDLE) ||
                              ((state == S_STOP) && (baud_cnt == '0)));
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (!reset && push_ok) begin
      fifo_mem[wr_ptr] <= dmem_w_data_i[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full) begin
        overflow <= 1'b1;
      end else if (dmem_w_i && st_sel) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- UART FSM
  // uart_tx_o is registered and set on each transition so the line level
  // changes exactly on state / bit entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          uart_tx_o <= 1'b1;
          if (pop) begin
            shift     <= fifo_mem[rd_ptr];
            baud_cnt  <= BAUD_LOAD;
            state     <= S_START;
            uart_tx_o <= 1'b0;
          end
        end
        S_START: begin
          if (baud_cnt == '0) begin
            baud_cnt  <= BAUD_LOAD;
            bit_idx   <= '0;
            state     <= S_DATA;
            uart_tx_o <= shift[0];
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
              state     <= S_STOP;
              uart_tx_o <= 1'b1;
            end else begin
              // shift[1] is the bit that lands in shift[0] after this shift
              shift     <= shift >> 1;
              bit_idx   <= bit_idx + 1'b1;
              uart_tx_o <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (baud_cnt == '0) begin
            if (pop) begin
              shift     <= fifo_mem[rd_ptr];
              baud_cnt  <= BAUD_LOAD;
              state     <= S_START;
              uart_tx_o <= 1'b0;
            end else begin
              state     <= S_IDLE;
              uart_tx_o <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          uart_tx_o <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- CYCLE
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (dmem_w_i && cyc_sel) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------- read mux
  always_comb begin
    dmem_r_data_o = '0;
    if (ram_sel) begin
      dmem_r_data_o = mem[ram_idx];
    end else if (st_sel) begin
      dmem_r_data_o = {26'd0, overflow, busy, empty, full, 2'b00};
    end else if (cyc_sel) begin
      dmem_r_data_o = cycle_cnt;
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: randomized + directed bench for dmem_resp with a frame-level reference model.
// Latency: driver presents one bus operation per cycle; monitor samples on the falling edge.
// Backpressure: none; expected read data and UART line levels are queued and popped by the monitor.
module tb_dmem_resp;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_ST  = 32'h1000_0004;
  localparam logic [31:0] A_CYC = 32'h1000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dmem_addr_i;
  logic        dmem_w_i;
  logic [31:0] dmem_w_data_i;
  logic [31:0] dmem_r_data_o;
  logic        uart_tx_o;

  dmem_resp #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .dmem_addr_i   (dmem_addr_i),
    .dmem_w_i      (dmem_w_i),
    .dmem_w_data_i (dmem_w_data_i),
    .dmem_r_data_o (dmem_r_data_o),
    .uart_tx_o     (uart_tx_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------- model
  // Frame-level view: a byte leaves the queue when the transmitter takes it,
  // then occupies the line for FRAME cycles (start, 8 data LSB first, stop).
  logic [7:0]  m_q[$];
  bit          m_busy;
  int          m_rem;
  logic [7:0]  m_cur;
  bit          m_ovf;
  logic [31:0] m_cyc;
  bit          m_rst;
  logic [31:0] m_ram [int];

  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_ad_q[$];
  logic        exp_tx_q[$];
  logic        rd_chk = 1'b0;
  logic        tx_chk = 1'b0;

  int ram_pick[8] = '{0, 1, 4, 37, 128, 255, 510, 511};
  logic [31:0] unmapped[6] = '{32'h2000_0000, 32'h1000_000C, 32'h0000_0800,
                               32'hFFFF_FFFC, 32'h1000_0001, 32'h1000_0006};

  function automatic logic [31:0] m_status();
    return {26'd0, m_ovf, m_busy, (m_q.size() == 0), (m_q.size() == DEPTH), 2'b00};
  endfunction

  function automatic logic m_tx();
    int k;
    if (!m_busy) return 1'b1;
    k = (FRAME - m_rem) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_busy = 0;
    m_rem  = 0;
    m_cur  = '0;
    m_ovf  = 0;
    m_cyc  = '0;
  endtask

  // Advance the model across one rising edge given this cycle's bus operation.
  task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit full;
    bit take;
    if (m_rst) return;
    full = (m_q.size() == DEPTH);
    take = 0;
    if (m_busy) begin
      if (m_rem == 1) begin
        if (m_q.size() > 0) take = 1;
        else m_busy = 0;
      end else begin
        m_rem--;
      end
    end else if (m_q.size() > 0) begin
      take = 1;
    end
    if (take) begin
      m_cur  = m_q.pop_front();
      m_busy = 1;
      m_rem  = FRAME;
    end
    if (w && a == A_TX) begin
      if (full) m_ovf = 1;
      else m_q.push_back(d[7:0]);
    end
    if (w && a == A_ST) m_ovf = 0;
    m_cyc = (w && a == A_CYC) ? 32'd0 : m_cyc + 32'd1;
    if (w && a[31:11] == 21'd0) m_ram[int'(a[10:2])] = d;
  endtask

  // ---------------------------------------------------------------- driver
  // Called just after a rising edge; returns just after the next one.
  task automatic do_cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp;
    bit known;
    dmem_w_i      = w;
    dmem_addr_i   = a;
    dmem_w_data_i = d;
    known = 1;
    exp   = '0;
    if (a[31:11] == 21'd0) begin
      if (m_ram.exists(int'(a[10:2]))) exp = m_ram[int'(a[10:2])];
      else known = 0;
    end else if (a == A_ST) begin
      exp = m_status();
    end else if (a == A_CYC) begin
      exp = m_cyc;
    end
    rd_chk = known;
    if (known) begin
      exp_rd_q.push_back(exp);
      exp_ad_q.push_back(a);
    end
    tx_chk = 1'b1;
    exp_tx_q.push_back(m_tx());
    m_step(w, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, (i % 3 == 0) ? A_CYC : A_ST, 32'd0);
  endtask

  // Writes attempted while reset is held must have no effect.
  task automatic do_reset(input int n);
    reset = 1'b1;
    m_rst = 1;
    m_reset();
    for (int i = 0; i < n; i++) begin
      do_cycle(1'b1, (i % 2 == 0) ? A_ST : A_CYC, 32'hFFFF_FFFF);
    end
    do_cycle(1'b1, 32'h0000_0040, 32'h0BAD_0BAD);
    reset = 1'b0;
    m_rst = 0;
  endtask

  function automatic logic [31:0] ram_addr();
    return {21'd0, 9'(ram_pick[$urandom_range(0, 7)]), 2'($urandom_range(0, 3))};
  endfunction

  // ---------------------------------------------------------------- monitor
  logic [31:0] e_rd;
  logic [31:0] e_ad;
  logic        e_tx;

  always @(negedge clk) begin
    if (rd_chk) begin
      n_checks++;
      if (exp_rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_queue: read presented with no expectation queued");
      end else begin
        e_rd = exp_rd_q.pop_front();
        e_ad = exp_ad_q.pop_front();
        if (dmem_r_data_o !== e_rd) begin
          n_fail++;
          $display("FAIL read addr=%08h got=%08h exp=%08h t=%0t", e_ad, dmem_r_data_o, e_rd, $time);
        end
      end
    end
    if (tx_chk) begin
      n_checks++;
      if (exp_tx_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_queue: line sample with no expectation queued");
      end else begin
        e_tx = exp_tx_q.pop_front();
        if (uart_tx_o !== e_tx) begin
          n_fail++;
          $display("FAIL uart_tx got=%b exp=%b t=%0t", uart_tx_o, e_tx, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int r;
    int pct;
    reset         = 1'b1;
    dmem_w_i      = 1'b0;
    dmem_addr_i   = '0;
    dmem_w_data_i = '0;
    m_rst         = 1;
    m_reset();
    @(posedge clk);
    #1;
    do_reset(3);

    // RAM: read-during-write returns old word, new word visible next cycle
    do_cycle(1'b1, 32'h0000_0010, 32'h1111_1111);
    do_cycle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    do_cycle(1'b0, 32'h0000_0010, 32'd0);
    do_cycle(1'b0, 32'h0000_0013, 32'd0);
    do_cycle(1'b1, 32'h0000_07FC, 32'hCAFE_F00D);
    do_cycle(1'b0, 32'h0000_07FF, 32'd0);

    // UART single byte
    do_cycle(1'b1, A_TX, 32'h0000_00A5);
    idle(FRAME + 6);

    // FIFO full / overflow, back-to-back frames, overflow clear
    for (int i = 1; i <= 6; i++) do_cycle(1'b1, A_TX, 32'(i));
    idle(10);
    do_cycle(1'b1, A_ST, 32'd0);
    idle(5 * FRAME + 10);

    // CYCLE: clear and resume
    idle(3);
    do_cycle(1'b1, A_CYC, 32'h1234_5678);
    do_cycle(1'b0, A_CYC, 32'd0);
    do_cycle(1'b0, A_CYC, 32'd0);

    // Unmapped write changes nothing
    do_cycle(1'b1, 32'h2000_0000, 32'h1234_5678);
    do_cycle(1'b0, 32'h2000_0000, 32'd0);
    do_cycle(1'b0, 32'h0000_0010, 32'd0);
    idle(3);

    // Reset during DATA bit 3, then a clean frame; RAM write under reset ignored
    do_cycle(1'b1, 32'h0000_0040, 32'h0000_0040);
    do_cycle(1'b1, A_TX, 32'h0000_005A);
    idle(2 + 4 * CPB + 1);
    do_reset(2);
    do_cycle(1'b0, 32'h0000_0040, 32'd0);
    do_cycle(1'b1, A_TX, 32'h0000_003C);
    idle(FRAME + 6);

    // Randomized: heavy then light TX traffic
    for (int ph = 0; ph < 2; ph++) begin
      pct = (ph == 0) ? 30 : 3;
      for (int i = 0; i < 1500; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < pct) do_cycle(1'b1, A_TX, $urandom);
        else if (r < pct + 3) do_cycle(1'b1, A_ST, $urandom);
        else if (r < pct + 5) do_cycle(1'b1, A_CYC, $urandom);
        else if (r < pct + 20) do_cycle(1'b1, ram_addr(), $urandom);
        else if (r < pct + 40) do_cycle(1'b0, ram_addr(), 32'd0);
        else if (r < pct + 45) do_cycle(1'($urandom_range(0, 1)), unmapped[$urandom_range(0, 5)], $urandom);
        else if (r == 99 && $urandom_range(0, 3) == 0) do_reset(2);
        else do_cycle(1'b0, (r % 2 == 1) ? A_ST : A_CYC, 32'd0);
      end
    end
    idle((DEPTH + 1) * FRAME + 20);

    rd_chk = 1'b0;
    tx_chk = 1'b0;
    #1;
    n_checks++;
    if (exp_rd_q.size() != 0 || exp_tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover expectations rd=%0d tx=%0d exp=0", exp_rd_q.size(), exp_tx_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
